framebuffer_fetch_multi: RTL and testbench
==========================================

Name: framebuffer_fetch_multi

Overview:
Parametrised successor to the single-word pixel fetch. For one (row, column) request it fetches one RAM word per panel chain, sequenced back-to-back, and compensates for a configurable RAM read latency. It double-buffers the result so all chains' top/bottom pixel data update atomically with a one-cycle valid strobe. It sits between the row/column scan controller and the framebuffer RAM read port, and feeds the per-chain RGB shift-out logic.

Parameters:
BITS_PER_SUBPANEL, 16, bits per pixel per half-panel; a RAM word is 2*BITS_PER_SUBPANEL wide.
COLUMN_BITS, 6, column address width (64 columns).
ROW_BITS, 4, half-height row address width (16 rows).
NUM_CHAINS, 2, number of parallel panel chains; range 1..8.
RAM_LATENCY, 1, cycles from address to sampleable data; range 1..3.
CHAIN_BITS, max(1,$clog2(NUM_CHAINS)), derived; not overridden.

Ports:
clk_in  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-low reset
column_address  input  COLUMN_BITS  column to fetch; sampled with pixel_load_start
row_address  input  ROW_BITS  half-height row to fetch; sampled with pixel_load_start
pixel_load_start  input  1  fetch request; sampled at a rising edge
clear_overrun  input  1  clears the sticky overrun flag
ram_data_in  input  2*BITS_PER_SUBPANEL  RAM read data, laid out as {bottom, top}
ram_address  output  CHAIN_BITS+ROW_BITS+COLUMN_BITS  registered address, laid out as {chain, row, column}
ram_clk_enable  output  1  RAM read clock enable
pixeldata_top  output  NUM_CHAINS*BITS_PER_SUBPANEL  chain c at [c*BITS_PER_SUBPANEL +: BITS_PER_SUBPANEL]
pixeldata_bottom  output  NUM_CHAINS*BITS_PER_SUBPANEL  same packing as pixeldata_top
pixel_valid  output  1  one-cycle strobe; outputs were updated at this edge
busy  output  1  fetch in progress; starts are not accepted
overrun  output  1  sticky; set when a start arrives while busy

Behaviour:
- Reset (reset==0 at an edge): all outputs and internal state go to 0 and the FSM goes to IDLE. Reset takes priority over every other input, including mid-fetch. RAM data still in flight is discarded; it is never committed.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE: pixel_load_start==1 at edge T. Row and column are latched at T; busy=1 after T.
  - ISSUE: after edge T+1+c, ram_address={c,row,col} for c=0..NUM_CHAINS-1.
  - ISSUE -> DRAIN: after the last chain's address is issued.
  - DRAIN -> IDLE: at the edge that captures the final word.
- ram_clk_enable is 1 for the cycles following edges T+1 .. T+NUM_CHAINS+RAM_LATENCY-1, and 0 otherwise.
- Capture: ram_data_in is sampled at edge T+1+c+RAM_LATENCY into the chain-c staging slot. Tracking uses a RAM_LATENCY-deep valid/chain-tag pipeline, not a timer compare. Low half goes to top, high half to bottom.
- Commit at edge T+NUM_CHAINS+RAM_LATENCY:
  - the last word goes direct to the outputs;
  - all other slots copy from staging to pixeldata_top/bottom in the same edge;
  - pixel_valid=1 for exactly that cycle; busy=0 from that edge.
  - Fetch latency is NUM_CHAINS+RAM_LATENCY cycles.
- Outputs hold their last committed value between commits and never show partial (mixed) data.
- Back-to-back: a start asserted in the cycle where pixel_valid==1 (busy==0) is accepted. Sustained throughput is one fetch per NUM_CHAINS+RAM_LATENCY+0 idle cycles.
- Start while busy==1: ignored; the fetch continues unaffected and overrun is set to 1.
- clear_overrun==1 clears overrun, except that a same-cycle set wins.
- ram_address holds its last value while idle.
- Width rule: no arithmetic on addresses; the chain index is zero-extended into CHAIN_BITS.

Test Plan:
1. Reset/idle, defaults (N=2, L=1): hold reset=0 for 3 cycles. -> all outputs 0; ram_clk_enable=0; busy=0.
2. Single fetch, defaults: start at T with row=5, col=0x2A; RAM model returns word=addr-dependent pattern. -> ram_address=0x16A at T+1 and 0x56A at T+2; pixel_valid pulses at T+3; pixeldata_top/bottom show both chains' halves at the correct offsets.
3. Latency sweep: N=4, L=3, start at T. -> captures at T+4..T+7; single valid pulse at T+7; ram_clk_enable high for exactly 6 cycles.
4. Back-to-back plus overrun:
   - start again in the pixel_valid cycle -> accepted, second valid at +3.
   - start at T+1 -> overrun=1, no extra fetch.
   - clear_overrun alone -> overrun=0.
   - clear and illegal start in the same cycle -> overrun stays 1.
5. Reset mid-fetch: reset=0 at T+2, released at T+3, with RAM still driving data. -> outputs 0, no valid pulse; a new start at T+4 completes normally.
6. N=1 corner: CHAIN_BITS=1, ram_address MSB=0. -> valid at T+1+L; ram_clk_enable high for L cycles.

Source files
------------

// File: rtl/framebuffer_fetch_multi_if.sv
// Scan-controller / RAM-port bundle for the multi-chain pixel fetch.
// The fetch unit is the slave; the scan controller and RAM model drive the master side.
interface framebuffer_fetch_multi_if #(
    parameter int BITS_PER_SUBPANEL = 16,
    parameter int COLUMN_BITS       = 6,
    parameter int ROW_BITS          = 4,
    parameter int NUM_CHAINS        = 2
);
    localparam int CHAIN_BITS = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
    localparam int AW         = CHAIN_BITS + ROW_BITS + COLUMN_BITS;

    logic [COLUMN_BITS-1:0]                  column_address;
    logic [ROW_BITS-1:0]                     row_address;
    logic                                    pixel_load_start;
    logic                                    clear_overrun;
    logic [2*BITS_PER_SUBPANEL-1:0]          ram_data_in;
    logic [AW-1:0]                           ram_address;
    logic                                    ram_clk_enable;
    logic [NUM_CHAINS*BITS_PER_SUBPANEL-1:0] pixeldata_top;
    logic [NUM_CHAINS*BITS_PER_SUBPANEL-1:0] pixeldata_bottom;
    logic                                    pixel_valid;
    logic                                    busy;
    logic                                    overrun;

    modport master (
        output column_address, row_address, pixel_load_start, clear_overrun, ram_data_in,
        input  ram_address, ram_clk_enable, pixeldata_top, pixeldata_bottom,
               pixel_valid, busy, overrun
    );

    modport slave (
        input  column_address, row_address, pixel_load_start, clear_overrun, ram_data_in,
        output ram_address, ram_clk_enable, pixeldata_top, pixeldata_bottom,
               pixel_valid, busy, overrun
    );
endinterface

// File: rtl/framebuffer_fetch_multi.sv
// Fetches one RAM word per panel chain for a (row, column) request, tracks the RAM
// latency with a tagged valid pipe and commits all chains atomically with one strobe.
module framebuffer_fetch_multi #(
    parameter int BITS_PER_SUBPANEL = 16,
    parameter int COLUMN_BITS       = 6,
    parameter int ROW_BITS          = 4,
    parameter int NUM_CHAINS        = 2,
    parameter int RAM_LATENCY       = 1
) (
    input  logic                       clk_in,
    input  logic                       reset,
    framebuffer_fetch_multi_if.slave   bus
);
    localparam int CHAIN_BITS = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
    localparam int AW         = CHAIN_BITS + ROW_BITS + COLUMN_BITS;
    localparam int B          = BITS_PER_SUBPANEL;
    localparam logic [CHAIN_BITS-1:0] LAST = CHAIN_BITS'(NUM_CHAINS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [ROW_BITS-1:0]    row_q;
    logic [COLUMN_BITS-1:0] col_q;
    logic [CHAIN_BITS-1:0]  cnt_q;
    logic [AW-1:0]          addr_q;
    logic [RAM_LATENCY-1:0] vld_pipe_q;
    logic [CHAIN_BITS-1:0]  tag_q [RAM_LATENCY];
    logic                   valid_q, overrun_q;
    logic                   accept, issue, land, commit;

    assign accept = (state_q == IDLE) && bus.pixel_load_start;
    assign issue  = (state_q == ISSUE);
    assign land   = vld_pipe_q[RAM_LATENCY-1];
    assign commit = land && (tag_q[RAM_LATENCY-1] == LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.pixel_load_start) state_d = ISSUE;
            ISSUE:   if (cnt_q == LAST)        state_d = DRAIN;
            DRAIN:   if (commit)               state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            vld_pipe_q <= '0;
            for (int k = 0; k < RAM_LATENCY; k++) tag_q[k] <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                row_q <= bus.row_address;
                col_q <= bus.column_address;
                cnt_q <= '0;
            end else if (issue) begin
                cnt_q <= cnt_q + CHAIN_BITS'(1);
            end
            if (issue) addr_q <= {cnt_q, row_q, col_q};
            // Each issued address carries its chain tag down the latency pipe.
            vld_pipe_q[0] <= issue;
            tag_q[0]      <= cnt_q;
            for (int k = 1; k < RAM_LATENCY; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                tag_q[k]      <= tag_q[k-1];
            end
            valid_q <= commit;
            if (bus.pixel_load_start && (state_q != IDLE)) overrun_q <= 1'b1;
            else if (bus.clear_overrun)                   overrun_q <= 1'b0;
        end
    end

    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
        localparam logic [CHAIN_BITS-1:0] ID = CHAIN_BITS'(c);
        logic [B-1:0] top_q, bot_q;

        if (c == NUM_CHAINS - 1) begin : g_last
            // Final word bypasses staging so the commit lands on the capture edge.
            always_ff @(posedge clk_in) begin
                if (!reset) begin
                    top_q <= '0;
                    bot_q <= '0;
                end else if (commit) begin
                    top_q <= bus.ram_data_in[B-1:0];
                    bot_q <= bus.ram_data_in[2*B-1:B];
                end
            end
        end else begin : g_staged
            logic [B-1:0] stg_top_q, stg_bot_q;
            always_ff @(posedge clk_in) begin
                if (!reset) begin
                    stg_top_q <= '0;
                    stg_bot_q <= '0;
                    top_q     <= '0;
                    bot_q     <= '0;
                end else begin
                    if (land && (tag_q[RAM_LATENCY-1] == ID)) begin
                        stg_top_q <= bus.ram_data_in[B-1:0];
                        stg_bot_q <= bus.ram_data_in[2*B-1:B];
                    end
                    if (commit) begin
                        top_q <= stg_top_q;
                        bot_q <= stg_bot_q;
                    end
                end
            end
        end

        assign bus.pixeldata_top[c*B +: B]    = top_q;
        assign bus.pixeldata_bottom[c*B +: B] = bot_q;
    end

    assign bus.ram_address    = addr_q;
    assign bus.ram_clk_enable = |vld_pipe_q;
    assign bus.pixel_valid    = valid_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_framebuffer_fetch_multi.sv
// Drives three fetch configurations (N=2/L=1, N=4/L=3, N=1/L=2) from shared stimulus and
// compares every output each cycle against a cycle-count model of the fetch timeline.
module tb_framebuffer_fetch_multi;
    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       rst_n = 1'b0, start = 1'b0, clr = 1'b0;
    logic [3:0] row = '0;
    logic [5:0] col = '0;
    logic [31:0] mem [8192];

    framebuffer_fetch_multi_if #(.NUM_CHAINS(2)) if0 ();
    framebuffer_fetch_multi_if #(.NUM_CHAINS(4)) if1 ();
    framebuffer_fetch_multi_if #(.NUM_CHAINS(1)) if2 ();

    framebuffer_fetch_multi #(.NUM_CHAINS(2), .RAM_LATENCY(1)) u0 (.clk_in(clk_in), .reset(rst_n), .bus(if0));
    framebuffer_fetch_multi #(.NUM_CHAINS(4), .RAM_LATENCY(3)) u1 (.clk_in(clk_in), .reset(rst_n), .bus(if1));
    framebuffer_fetch_multi #(.NUM_CHAINS(1), .RAM_LATENCY(2)) u2 (.clk_in(clk_in), .reset(rst_n), .bus(if2));

    assign if0.column_address = col;  assign if1.column_address = col;  assign if2.column_address = col;
    assign if0.row_address = row;     assign if1.row_address = row;     assign if2.row_address = row;
    assign if0.pixel_load_start = start; assign if1.pixel_load_start = start; assign if2.pixel_load_start = start;
    assign if0.clear_overrun = clr;   assign if1.clear_overrun = clr;   assign if2.clear_overrun = clr;

    // RAM model: data for an address is sampleable L edges after the address appears.
    logic [11:0] ah1 [2] = '{12'd0, 12'd0};
    logic [10:0] ah2 = '0;
    always @(posedge clk_in) begin
        ah1[0] <= if1.ram_address;
        ah1[1] <= ah1[0];
        ah2    <= if2.ram_address;
    end
    assign if0.ram_data_in = mem[13'(if0.ram_address)];
    assign if1.ram_data_in = mem[13'(ah1[1])];
    assign if2.ram_data_in = mem[13'(ah2)];

    // Reference model state, one slot per configuration.
    int           NP [3] = '{2, 4, 1};
    int           LP [3] = '{1, 3, 2};
    int           cyc = 0;
    bit           m_busy [3], m_valid [3], m_ovr [3], m_ce [3];
    int           m_T [3];
    logic [3:0]   m_row [3];
    logic [5:0]   m_col [3];
    logic [127:0] m_addr [3], m_top [3], m_bot [3];
    int           n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int addr_of(input int c, input logic [3:0] r, input logic [5:0] k);
        return c * 1024 + int'(r) * 64 + int'(k);
    endfunction

    task automatic model_step();
        cyc++;
        for (int i = 0; i < 3; i++) begin
            bit busy_before;
            int k;
            if (!rst_n) begin
                m_busy[i] = 0; m_valid[i] = 0; m_ovr[i] = 0; m_ce[i] = 0;
                m_addr[i] = '0; m_top[i] = '0; m_bot[i] = '0;
                continue;
            end
            busy_before = m_busy[i];
            m_valid[i]  = 0;
            m_ce[i]     = 0;
            if (m_busy[i]) begin
                k = cyc - m_T[i];
                if (k >= 1 && k <= NP[i]) m_addr[i] = 128'(addr_of(k - 1, m_row[i], m_col[i]));
                m_ce[i] = (k >= 1 && k <= NP[i] + LP[i] - 1);
                if (k == NP[i] + LP[i]) begin
                    m_top[i] = '0;
                    m_bot[i] = '0;
                    for (int c = 0; c < NP[i]; c++) begin
                        logic [31:0] w;
                        w = mem[13'(addr_of(c, m_row[i], m_col[i]))];
                        m_top[i] = m_top[i] | (128'(w[15:0]) << (16 * c));
                        m_bot[i] = m_bot[i] | (128'(w[31:16]) << (16 * c));
                    end
                    m_valid[i] = 1;
                    m_busy[i]  = 0;
                end
            end
            if (start && busy_before) m_ovr[i] = 1;
            else if (clr)             m_ovr[i] = 0;
            if (start && !busy_before) begin
                m_busy[i] = 1;
                m_T[i]    = cyc;
                m_row[i]  = row;
                m_col[i]  = col;
            end
        end
    endtask

    task automatic check_inst(input int i, input logic [127:0] a, input logic ce,
                              input logic [127:0] t, input logic [127:0] b,
                              input logic v, input logic bz, input logic ov);
        chk($sformatf("u%0d.ram_address", i), a, m_addr[i]);
        chk($sformatf("u%0d.ram_clk_enable", i), 128'(ce), 128'(m_ce[i]));
        chk($sformatf("u%0d.pixeldata_top", i), t, m_top[i]);
        chk($sformatf("u%0d.pixeldata_bottom", i), b, m_bot[i]);
        chk($sformatf("u%0d.pixel_valid", i), 128'(v), 128'(m_valid[i]));
        chk($sformatf("u%0d.busy", i), 128'(bz), 128'(m_busy[i]));
        chk($sformatf("u%0d.overrun", i), 128'(ov), 128'(m_ovr[i]));
    endtask

    task automatic cycle_in(input bit r, input bit s, input bit cl, input logic [3:0] rw, input logic [5:0] cc);
        @(negedge clk_in);
        check_inst(0, 128'(if0.ram_address), if0.ram_clk_enable, 128'(if0.pixeldata_top),
                   128'(if0.pixeldata_bottom), if0.pixel_valid, if0.busy, if0.overrun);
        check_inst(1, 128'(if1.ram_address), if1.ram_clk_enable, 128'(if1.pixeldata_top),
                   128'(if1.pixeldata_bottom), if1.pixel_valid, if1.busy, if1.overrun);
        check_inst(2, 128'(if2.ram_address), if2.ram_clk_enable, 128'(if2.pixeldata_top),
                   128'(if2.pixeldata_bottom), if2.pixel_valid, if2.busy, if2.overrun);
        rst_n = r; start = s; clr = cl; row = rw; col = cc;
        @(posedge clk_in);
        model_step();
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = $urandom;
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 0; m_valid[i] = 0; m_ovr[i] = 0; m_ce[i] = 0;
            m_addr[i] = '0; m_top[i] = '0; m_bot[i] = '0; m_T[i] = 0;
            m_row[i] = '0; m_col[i] = '0;
        end
        // Reset held for three edges before any checking.
        repeat (3) begin
            @(posedge clk_in);
            model_step();
        end
        cycle_in(0, 0, 0, 4'd0, 6'd0);
        // Single fetch row=5 col=0x2A, then let the slowest configuration drain.
        cycle_in(1, 1, 0, 4'd5, 6'h2A);
        repeat (10) cycle_in(1, 0, 0, 4'd0, 6'd0);
        // Back-to-back, overrun while busy, clear alone, clear racing an illegal start.
        cycle_in(1, 1, 0, 4'd3, 6'h11);
        cycle_in(1, 0, 0, 4'd0, 6'd0);
        cycle_in(1, 1, 0, 4'd7, 6'h3F);
        cycle_in(1, 0, 0, 4'd0, 6'd0);
        cycle_in(1, 1, 0, 4'd9, 6'h05);
        cycle_in(1, 0, 1, 4'd0, 6'd0);
        cycle_in(1, 1, 1, 4'd1, 6'h01);
        repeat (10) cycle_in(1, 0, 0, 4'd0, 6'd0);
        cycle_in(1, 0, 1, 4'd0, 6'd0);
        // Reset mid-fetch with RAM still driving, then a clean fetch.
        cycle_in(1, 1, 0, 4'd15, 6'h00);
        cycle_in(1, 0, 0, 4'd0, 6'd0);
        cycle_in(0, 0, 0, 4'd0, 6'd0);
        cycle_in(1, 0, 0, 4'd0, 6'd0);
        cycle_in(1, 1, 0, 4'd12, 6'h34);
        repeat (10) cycle_in(1, 0, 0, 4'd0, 6'd0);
        // Randomised traffic: frequent starts, occasional clears and resets.
        for (int n = 0; n < 3000; n++) begin
            cycle_in($urandom_range(0, 59) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 4) == 0, 4'($urandom), 6'($urandom));
        end
        @(negedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
